// File: rtl/mpc_pkg.sv
// Shared constants and FSM encoding for the block-address prefetcher.
package mpc_pkg;

    localparam int MPC_AWIDTH = 10;
    localparam int MPC_DEPTH  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FLUSH = 2'd2
    } mpc_state_e;

endpackage

// File: rtl/addr_fifo.sv
// Show-ahead FIFO of block addresses: head is valid combinationally whenever not empty.
module addr_fifo import mpc_pkg::*; #(
    parameter int AWIDTH = MPC_AWIDTH,
    parameter int DEPTH  = MPC_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [AWIDTH-1:0]        push_data,
    input  logic                     pop,
    output logic [AWIDTH-1:0]        head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [AWIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally; the occupancy counter disambiguates full from empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q | (push && full);
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: its contents are only observed through level-qualified paths.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/blk_addr_prefetch.sv
// Prefetches occupied block addresses from mem_manager into a show-ahead FIFO and
// returns unused ones through the release port on flush.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no request outstanding; FIFO full or flush just finished
// ST_REQ   | ocp_req held high, waiting for ocp_rsp (flush may be pending)
// ST_FLUSH | draining FIFO to release port, alloc side blocked
module blk_addr_prefetch import mpc_pkg::*; #(
    parameter int AWIDTH = MPC_AWIDTH,
    parameter int DEPTH  = MPC_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     ocp_req,
    input  logic                     ocp_rsp,
    input  logic [AWIDTH-1:0]        ocp_block_addr,
    input  logic                     ocp_vld,
    output logic                     alloc_vld,
    output logic [AWIDTH-1:0]        alloc_addr,
    input  logic                     alloc_rdy,
    input  logic                     flush,
    output logic                     flush_done,
    output logic [AWIDTH-1:0]        rls_block_addr,
    output logic                     rls_vld,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf_err
);

    localparam int LW = $clog2(DEPTH) + 1;

    mpc_state_e        state_q, state_d;
    logic              ocp_req_q, ocp_req_d;
    logic              flush_pend_q, flush_pend_d;
    logic              rls_vld_q, rls_vld_d;
    logic [AWIDTH-1:0] rls_addr_q, rls_addr_d;

    logic [AWIDTH-1:0] fifo_head;
    logic [LW-1:0]     fifo_level;
    logic              fifo_full, fifo_empty, fifo_ovf;

    logic              fifo_push, fifo_pop;
    logic              alloc_pop, flush_pop;
    logic              flush_any, drain_done;
    logic [LW-1:0]     level_nxt;

    addr_fifo #(
        .AWIDTH (AWIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (ocp_block_addr),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .ovf       (fifo_ovf)
    );

    assign alloc_vld  = (state_q != ST_FLUSH) && !fifo_empty;
    assign alloc_pop  = alloc_vld && alloc_rdy;
    assign flush_pop  = (state_q == ST_FLUSH) && !fifo_empty;
    assign fifo_pop   = alloc_pop || flush_pop;
    assign fifo_push  = (state_q == ST_REQ) && ocp_rsp && ocp_vld;
    assign flush_any  = flush || flush_pend_q;
    // Done only once the last popped address has left the release register.
    assign drain_done = (state_q == ST_FLUSH) && fifo_empty && !rls_vld_q;

    always_comb begin
        level_nxt = fifo_level;
        if (fifo_push && !fifo_full) begin
            level_nxt = level_nxt + LW'(1);
        end
        if (fifo_pop && !fifo_empty) begin
            level_nxt = level_nxt - LW'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                end else if (!fifo_full) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                // The request is never withdrawn: leave only on a response.
                if (ocp_rsp) begin
                    if (flush_any) begin
                        state_d = ST_FLUSH;
                    end else if (level_nxt >= LW'(DEPTH)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                if (drain_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_FLUSH) begin
            flush_pend_d = 1'b0;
        end
    end

    assign ocp_req_d  = (state_d == ST_REQ);
    assign rls_vld_d  = flush_pop;
    assign rls_addr_d = flush_pop ? fifo_head : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ocp_req_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            rls_vld_q    <= 1'b0;
            rls_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            ocp_req_q    <= ocp_req_d;
            flush_pend_q <= flush_pend_d;
            rls_vld_q    <= rls_vld_d;
            rls_addr_q   <= rls_addr_d;
        end
    end

    assign ocp_req        = ocp_req_q;
    assign alloc_addr     = alloc_vld ? fifo_head : '0;
    assign flush_done     = drain_done;
    assign rls_block_addr = rls_addr_q;
    assign rls_vld        = rls_vld_q;
    assign level          = fifo_level;
    assign ovf_err        = fifo_ovf;

endmodule

// File: tb/tb_blk_addr_prefetch.sv
// Bench for blk_addr_prefetch with a behavioural mem_manager and an address scoreboard.
module tb_blk_addr_prefetch;

    localparam int AW = 10;
    localparam int DP = 4;
    localparam int LW = $clog2(DP) + 1;
    localparam int NV = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ocp_req;
    logic          ocp_rsp;
    logic [AW-1:0] ocp_block_addr;
    logic          ocp_vld;
    logic          alloc_vld;
    logic [AW-1:0] alloc_addr;
    logic          alloc_rdy = 1'b0;
    logic          flush = 1'b0;
    logic          flush_done;
    logic [AW-1:0] rls_block_addr;
    logic          rls_vld;
    logic [LW-1:0] level;
    logic          ovf_err;

    always #5 clk = ~clk;

    blk_addr_prefetch #(.AWIDTH(AW), .DEPTH(DP)) dut (
        .clk            (clk),
        .rst            (rst),
        .ocp_req        (ocp_req),
        .ocp_rsp        (ocp_rsp),
        .ocp_block_addr (ocp_block_addr),
        .ocp_vld        (ocp_vld),
        .alloc_vld      (alloc_vld),
        .alloc_addr     (alloc_addr),
        .alloc_rdy      (alloc_rdy),
        .flush          (flush),
        .flush_done     (flush_done),
        .rls_block_addr (rls_block_addr),
        .rls_vld        (rls_vld),
        .level          (level),
        .ovf_err        (ovf_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // mem_manager model: sees a request one edge after it rises, answers m_delay cycles later
    logic          m_busy;
    int            m_cnt;
    logic [AW-1:0] m_next;
    logic          m_full  = 1'b0;
    logic          m_drop  = 1'b0;
    int            m_delay = 0;
    logic [AW-1:0] exp_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ocp_rsp        <= 1'b0;
            ocp_vld        <= 1'b0;
            ocp_block_addr <= '0;
            m_busy         <= 1'b0;
            m_cnt          <= 0;
            m_next         <= '0;
            exp_q.delete();
        end else begin
            ocp_rsp        <= 1'b0;
            ocp_vld        <= 1'b0;
            ocp_block_addr <= '0;
            if (ocp_rsp) begin
                m_busy <= 1'b0;
            end else if (!m_busy) begin
                if (ocp_req) begin
                    m_busy <= 1'b1;
                    m_cnt  <= m_delay;
                end
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
            end else if (!m_full) begin
                ocp_rsp <= 1'b1;
                if (!m_drop) begin
                    ocp_vld        <= 1'b1;
                    ocp_block_addr <= m_next;
                    m_next         <= m_next + 1'b1;
                    exp_q.push_back(m_next);
                end
            end
        end
    end

    int            cyc = 0;
    int            rls_cnt = 0;
    int            rls_last = 0;
    logic [AW-1:0] rls_last_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor samples just before the rising edge, after the main thread has driven inputs.
    always @(negedge clk) begin
        #4;
        if (!rst) begin
            if (alloc_vld && alloc_rdy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL alloc_unexpected: got addr %0d, expected no transfer", alloc_addr);
                end else begin
                    check("alloc_addr", alloc_addr, exp_q.pop_front());
                end
            end
            if (rls_vld) begin
                rls_cnt++;
                rls_last      = cyc;
                rls_last_addr = rls_block_addr;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rls_unexpected: got addr %0d, expected no release", rls_block_addr);
                end else begin
                    check("rls_addr", rls_block_addr, exp_q.pop_front());
                end
            end
        end
    end

    typedef struct {
        logic          alloc_rdy;
        logic          flush;
        logic          exp_req;
        logic [LW-1:0] exp_level;
        logic          exp_vld;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t tv[NV];
    int   lvl_tab[NV] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4};
    int   req_tab[NV] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // Reset, then follow the post-reset refill cycle by cycle against the table.
    task automatic run_trace(input string tag);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < NV; i++) begin
            alloc_rdy = tv[i].alloc_rdy;
            flush     = tv[i].flush;
            check({tag, "_ocp_req"}, ocp_req, tv[i].exp_req);
            check({tag, "_level"}, level, tv[i].exp_level);
            check({tag, "_alloc_vld"}, alloc_vld, tv[i].exp_vld);
            check({tag, "_alloc_addr"}, alloc_addr, tv[i].exp_addr);
            tick();
        end
    endtask

    task automatic wait_level(input string name, input int lv, output int t);
        for (int i = 0; i < 60 && level != lv; i++) tick();
        check(name, level, lv);
        t = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, t3, rls_base, bad, lv;

        for (int i = 0; i < NV; i++) begin
            tv[i].alloc_rdy = 1'b0;
            tv[i].flush     = 1'b0;
            tv[i].exp_req   = (req_tab[i] != 0);
            tv[i].exp_level = LW'(lvl_tab[i]);
            tv[i].exp_vld   = (lvl_tab[i] != 0);
            tv[i].exp_addr  = '0;
        end

        // 1: reset and immediate-grant refill
        run_trace("t1");

        // 2: drain the full FIFO on consecutive cycles, then watch refill rate
        alloc_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t2_alloc_vld", alloc_vld, 1);
            check("t2_alloc_addr", alloc_addr, i);
            tick();
        end
        alloc_rdy = 1'b0;
        wait_level("t2_level1", 1, t1);
        wait_level("t2_level2", 2, t2);
        wait_level("t2_level3", 3, t3);
        check("t2_refill_gap_a", t2 - t1, 3);
        check("t2_refill_gap_b", t3 - t2, 3);

        // 3: flush with three entries held and a request in flight
        rls_base = rls_cnt;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bad = 0;
        for (int i = 0; i < 40 && !flush_done; i++) begin
            if (rls_vld && alloc_vld) bad++;
            tick();
        end
        check("t3_flush_done", flush_done, 1);
        check("t3_alloc_blocked", bad, 0);
        check("t3_rls_count", rls_cnt - rls_base, 4);
        check("t3_last_rls_addr", rls_last_addr, 7);
        check("t3_done_after_last", cyc - rls_last, 1);
        check("t3_level", level, 0);
        m_full = 1'b1;
        tick();
        check("t3_done_pulse", flush_done, 0);

        // 4: mem_manager full for 20 cycles
        for (int i = 0; i < 20 && !ocp_req; i++) tick();
        check("t4_req_up", ocp_req, 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (!ocp_req || level != 0 || ocp_rsp) bad++;
            tick();
        end
        check("t4_hold", bad, 0);
        m_full = 1'b0;
        wait_level("t4_level1", 1, t1);
        check("t4_first_addr", alloc_addr, 8);

        // 5: response without ocp_vld is dropped
        m_drop = 1'b1;
        for (int i = 0; i < 20 && !ocp_rsp; i++) tick();
        check("t5_rsp_seen", ocp_rsp, 1);
        lv = int'(level);
        m_drop = 1'b0;
        tick();
        check("t5_level_kept", level, lv);
        check("t5_req_kept", ocp_req, 1);
        wait_level("t5_level2", 2, t1);
        check("t5_head", alloc_addr, 8);

        // 6: async reset in the middle of a flush
        wait_level("t6_level4", 4, t1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 20 && !rls_vld; i++) tick();
        check("t6_rls_started", rls_vld, 1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_outputs",
              {ocp_req, alloc_vld, alloc_addr, flush_done, rls_block_addr, rls_vld, level, ovf_err},
              0);
        run_trace("t6");

        check("ovf_err", ovf_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
